// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter sitting directly in front of the register bank write port.
// The ALU and the LSU each push register writes into a private circular FIFO.
// Every cycle in which either FIFO holds an entry, one head is popped. It is
// presented to the bank as a registered regsel/reg_val/reg_we triple.
// Writes to unimplemented register encodings are popped and dropped, and
// bad_rd is raised for one cycle instead of reg_we.
//
// Configuration macro:
//   WB_RR_EN  defined   -> round-robin arbitration between ALU and LSU.
//             undefined -> fixed priority, LSU over ALU (default build).
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int         DEPTH  = 4,
    parameter logic [5:0] REG_FP = 6'h16,
    parameter logic [5:0] REG_SP = 6'h17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [5:0]  alu_rd,
    input  logic [63:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [5:0]  lsu_rd,
    input  logic [63:0] lsu_data,
    output logic [5:0]  regsel,
    output logic [63:0] reg_val,
    output logic        reg_we,
    output logic        bad_rd,
    output logic        busy
);

    // Source indices into the per-source FIFO vectors.
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;

    // One FIFO entry is {rd, data}.
    localparam int ENTRY_W = 6 + 64;
    localparam int AW      = $clog2(DEPTH);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Per-source FIFO interface signals.
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic [1:0]         w_full;
    logic [1:0]         w_empty;
    logic [ENTRY_W-1:0] w_wdata [2];
    logic [ENTRY_W-1:0] w_head  [2];

    // Arbitration and output-stage signals.
    logic               w_any;
    logic               w_grant_lsu;
    logic [ENTRY_W-1:0] w_sel_entry;
    logic [5:0]         w_sel_rd;
    logic [63:0]        w_sel_data;
    logic               w_rd_valid;

    logic [5:0]         r_regsel;
    logic [63:0]        r_reg_val;
    logic               r_reg_we;
    logic               r_bad_rd;

    // A source may push whenever it asserts valid. The FIFO itself refuses
    // the push when it is full. Ready depends only on FIFO state, never on
    // valid.
    assign w_push[SRC_ALU]  = alu_valid;
    assign w_push[SRC_LSU]  = lsu_valid;
    assign w_wdata[SRC_ALU] = {alu_rd, alu_data};
    assign w_wdata[SRC_LSU] = {lsu_rd, lsu_data};

    assign alu_ready = !w_full[SRC_ALU];
    assign lsu_ready = !w_full[SRC_LSU];

    // Busy reflects pending work and is taken straight from the FIFO state.
    assign busy = !w_empty[SRC_ALU] || !w_empty[SRC_LSU];

    // -------------------------------------------------------------------------
    // Per-source circular FIFOs. The pointers carry an extra wrap bit, so full
    // and empty can be told apart when the index bits are equal.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ENTRY_W-1:0] r_mem [DEPTH];
        logic [AW:0]        r_wr_ptr;
        logic [AW:0]        r_rd_ptr;
        logic               w_do_push;
        logic               w_do_pop;

        assign w_full[g]  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                            (r_wr_ptr[AW]     != r_rd_ptr[AW]);
        assign w_empty[g] = (r_wr_ptr == r_rd_ptr);
        assign w_head[g]  = r_mem[r_rd_ptr[AW-1:0]];

        assign w_do_push  = w_push[g] && !w_full[g];
        assign w_do_pop   = w_pop[g]  && !w_empty[g];

        // Advance the read and write pointers. A reset empties the FIFO by
        // realigning both pointers.
        // NOTE: state registers use non-blocking assignments. All flops then
        // sample pre-edge values, and a simultaneous push and pop leaves the
        // occupancy unchanged.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end

        // Write the incoming entry at the write pointer.
        // NOTE: the storage array has no reset. The pointers alone define
        // which slots are live, so stale contents are never observed.
        always_ff @(posedge clk) begin
            if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata[g];
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef WB_RR_EN
    // Remembers which source won the last pop (1 = LSU). It resets to ALU, so
    // the LSU wins the first contended cycle.
    logic r_last_lsu;

    // Record the winner of every pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_lsu <= 1'b0;
        end else if (w_any) begin
            r_last_lsu <= w_grant_lsu;
        end
    end
`endif

    // Choose which source pops this cycle. Only FIFO state seen before the
    // edge is used, so a fresh push is never eligible in the same cycle.
    // NOTE: every always_comb output gets a default first. This prevents
    // latch inference on paths that do not assign it.
    always_comb begin
        w_any       = !w_empty[SRC_ALU] || !w_empty[SRC_LSU];
        w_grant_lsu = 1'b0;
`ifdef WB_RR_EN
        if (!w_empty[SRC_ALU] && !w_empty[SRC_LSU]) begin
            w_grant_lsu = !r_last_lsu;
        end else begin
            w_grant_lsu = !w_empty[SRC_LSU];
        end
`else
        w_grant_lsu = !w_empty[SRC_LSU];
`endif
    end

    // When the LSU is not granted but something is pending, the ALU FIFO must
    // be the non-empty one.
    assign w_pop[SRC_LSU] = w_grant_lsu;
    assign w_pop[SRC_ALU] = w_any && !w_grant_lsu;

    // -------------------------------------------------------------------------
    // Destination decode and output register
    // -------------------------------------------------------------------------
    assign w_sel_entry = w_grant_lsu ? w_head[SRC_LSU] : w_head[SRC_ALU];
    assign w_sel_rd    = w_sel_entry[ENTRY_W-1:64];
    assign w_sel_data  = w_sel_entry[63:0];

    // Implemented registers: general 0x00..0x0F, frame pointer, stack pointer.
    assign w_rd_valid  = (w_sel_rd[5:4] == 2'b00) ||
                         (w_sel_rd == REG_FP)     ||
                         (w_sel_rd == REG_SP);

    // Register the popped entry toward the bank. A valid destination raises
    // reg_we and an invalid one raises bad_rd. Idle cycles hold regsel and
    // reg_val.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regsel  <= '0;
            r_reg_val <= '0;
            r_reg_we  <= 1'b0;
            r_bad_rd  <= 1'b0;
        end else begin
            r_reg_we <= w_any && w_rd_valid;
            r_bad_rd <= w_any && !w_rd_valid;
            if (w_any) begin
                r_regsel  <= w_sel_rd;
                r_reg_val <= w_sel_data;
            end
        end
    end

    assign regsel  = r_regsel;
    assign reg_val = r_reg_val;
    assign reg_we  = r_reg_we;
    assign bad_rd  = r_bad_rd;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios and a randomized phase for wb_arbiter. Each cycle is
// compared against a queue-based reference model. The model holds one queue
// per source and applies the arbitration rule. WB_RR_EN selects the same
// arbitration mode as in the design.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [5:0]  rd;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [5:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [5:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic [5:0]  regsel;
    logic [63:0] reg_val;
    logic        reg_we;
    logic        bad_rd;
    logic        busy;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .regsel    (regsel),
        .reg_val   (reg_val),
        .reg_we    (reg_we),
        .bad_rd    (bad_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    wr_t         q_alu[$];
    wr_t         q_lsu[$];
    logic [5:0]  exp_regsel;
    logic [63:0] exp_val;
    logic        exp_we;
    logic        exp_bad;
`ifdef WB_RR_EN
    logic        last_lsu;
`endif

    // Destinations of issued writes, recorded while capture is set.
    logic        capture = 1'b0;
    logic [5:0]  seen_rd[$];

    function automatic logic rd_ok(input logic [5:0] rd);
        return (rd < 6'h10) || (rd == 6'h16) || (rd == 6'h17);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        check("regsel",  {58'd0, regsel}, {58'd0, exp_regsel});
        check("reg_val", reg_val, exp_val);
        check("reg_we",  {63'd0, reg_we}, {63'd0, exp_we});
        check("bad_rd",  {63'd0, bad_rd}, {63'd0, exp_bad});
        check("busy",    {63'd0, busy},
              {63'd0, (q_alu.size() > 0) || (q_lsu.size() > 0)});
    endtask

    // Reset for one cycle and clear the model. The caller is at a negedge.
    task automatic do_reset();
        reset     = 1'b1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(posedge clk);
        q_alu.delete();
        q_lsu.delete();
        exp_regsel = '0;
        exp_val    = '0;
        exp_we     = 1'b0;
        exp_bad    = 1'b0;
`ifdef WB_RR_EN
        last_lsu   = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    endtask

    // Run one clock cycle: drive inputs at the negedge, update the model at
    // the posedge, and compare outputs at the next negedge.
    task automatic step(input logic av, input logic [5:0] ard, input logic [63:0] ad,
                        input logic lv, input logic [5:0] lrd, input logic [63:0] ld);
        logic a_rdy;
        logic l_rdy;
        logic use_lsu;
        wr_t  e;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        a_rdy = (q_alu.size() < DEPTH);
        l_rdy = (q_lsu.size() < DEPTH);
        check("alu_ready", {63'd0, alu_ready}, {63'd0, a_rdy});
        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, l_rdy});
        @(posedge clk);
        exp_we  = 1'b0;
        exp_bad = 1'b0;
        if (q_alu.size() > 0 || q_lsu.size() > 0) begin
`ifdef WB_RR_EN
            if (q_alu.size() > 0 && q_lsu.size() > 0) use_lsu = !last_lsu;
            else use_lsu = (q_lsu.size() > 0);
            last_lsu = use_lsu;
`else
            use_lsu = (q_lsu.size() > 0);
`endif
            if (use_lsu) e = q_lsu.pop_front();
            else e = q_alu.pop_front();
            exp_regsel = e.rd;
            exp_val    = e.data;
            exp_we     = rd_ok(e.rd);
            exp_bad    = !rd_ok(e.rd);
        end
        if (av && a_rdy) q_alu.push_back({ard, ad});
        if (lv && l_rdy) q_lsu.push_back({lrd, ld});
        @(negedge clk);
        check_outputs();
        if (capture && reg_we) seen_rd.push_back(regsel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Safety net against a hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_seq [8];
        reset     = 1'b1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_rd    = '0;
        lsu_data  = '0;
        @(negedge clk);
        do_reset();

        // 1. Single ALU write, then return to idle.
        step(1'b1, 6'h03, 64'h1234, 1'b0, '0, '0);
        idle(1);
        check("t1_we",     {63'd0, reg_we}, 64'd1);
        check("t1_regsel", {58'd0, regsel}, 64'h03);
        check("t1_val",    reg_val, 64'h1234);
        idle(1);
        check("t1_we_off", {63'd0, reg_we}, 64'd0);
        check("t1_busy",   {63'd0, busy},   64'd0);

        // 2. Contention: the LSU wins first in both arbitration modes.
        do_reset();
        step(1'b1, 6'h01, 64'hA, 1'b1, 6'h02, 64'hB);
        idle(1);
        check("t2_first",  {58'd0, regsel}, 64'h02);
        check("t2_first_v", reg_val, 64'hB);
        idle(1);
        check("t2_second", {58'd0, regsel}, 64'h01);
        check("t2_second_v", reg_val, 64'hA);
        idle(1);

        // 3. LSU streams every cycle while the ALU fills its FIFO.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 6'(4 + i), 64'(16'hA000 + i), 1'b1, 6'h09, 64'(16'hB000 + i));
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, '0, 1'b1, 6'h09, 64'(16'hB100 + i));
`ifndef WB_RR_EN
        check("t3_alu_full", {63'd0, alu_ready}, 64'd0);
`endif
        idle(6);

        // 4. Invalid destination, followed by a stack-pointer write.
        step(1'b1, 6'h10, 64'hFF, 1'b0, '0, '0);
        step(1'b1, 6'h17, 64'h5555, 1'b0, '0, '0);
        check("t4_bad",    {63'd0, bad_rd}, 64'd1);
        check("t4_no_we",  {63'd0, reg_we}, 64'd0);
        idle(1);
        check("t4_sp_we",  {63'd0, reg_we}, 64'd1);
        check("t4_sp_sel", {58'd0, regsel}, 64'h17);
        idle(1);

        // 5. Reset with work pending in both FIFOs.
        for (int i = 0; i < 5; i++)
            step(1'b1, 6'(i), 64'(i), 1'b1, 6'(8 + i), 64'(100 + i));
        do_reset();
        idle(4);
        check("t5_busy", {63'd0, busy}, 64'd0);

        // 6. Four contended pushes per source; record the grant order.
        do_reset();
        seen_rd.delete();
        capture = 1'b1;
        for (int i = 0; i < 4; i++)
            step(1'b1, 6'(4 + i), 64'(i), 1'b1, 6'(8 + i), 64'(32 + i));
        idle(6);
        capture = 1'b0;
        check("t6_count", 64'(seen_rd.size()), 64'd8);
`ifdef WB_RR_EN
        exp_seq = '{6'h08, 6'h04, 6'h09, 6'h05, 6'h0A, 6'h06, 6'h0B, 6'h07};
        for (int i = 0; i < 8 && i < seen_rd.size(); i++)
            check("t6_order", {58'd0, seen_rd[i]}, {58'd0, exp_seq[i]});
`else
        exp_seq = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h06, 6'h07};
        for (int i = 0; i < 8 && i < seen_rd.size(); i++)
            check("t6_order", {58'd0, seen_rd[i]}, {58'd0, exp_seq[i]});
`endif

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            logic       av;
            logic       lv;
            logic [5:0] ard;
            logic [5:0] lrd;
            if (i == 200) do_reset();
            av  = ($urandom_range(0, 2) != 0);
            lv  = ($urandom_range(0, 2) == 0);
            ard = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15));
            lrd = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(22, 23)) : 6'($urandom);
            step(av, ard, {$urandom, $urandom}, lv, lrd, {$urandom, $urandom});
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
